pong_score_controller: RTL and testbench

- Match-level scoring controller for the Pong game. Accepts point pulses from the ball/paddle logic, holds both players' scores, and sequences the match through idle, play, point-pause and win phases.
- Gates gameplay via game_run and sets the serve direction.
- Drives score values and a per-digit blank mask into the 4-digit seven-segment display driver. Digit order, left to right: "0", P1 score, "0", P2 score.

---
 rtl/pong_score_controller.sv | 182 ++++++++++++++++++
 tb/tb_pong_score_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_score_controller.sv
`default_nettype none
// ============================================================================
// Module      : pong_score_controller
// Description : Match-level scoring for Pong. Holds both players' scores and
//               sequences IDLE -> PLAY -> POINT pause -> WIN. It gates the ball
//               logic with game_run, chooses the serve direction and drives
//               the score digits and blink mask for the seven-segment driver.
//               Optional macro AUTO_RESTART_EN: when defined, WIN returns to
//               IDLE by itself after HOLD_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_score_controller #(
    parameter int WIN_SCORE      = 9,
    parameter int HOLD_CYCLES    = 100000000,
    parameter int BLINK_DIV_BITS = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p1_point,
    input  logic       p2_point,
    input  logic       start,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [3:0] digit_blank,
    output logic       game_run,
    output logic       serve_dir,
    output logic [1:0] winner
);

    localparam int         c_HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [3:0] c_WIN       = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_POINT = 2'd2,
        S_WIN   = 2'd3
    } state_t;

    state_t                    r_state;
    logic [c_HOLD_W-1:0]       r_hold;
    logic                      r_last_p2;
    logic [BLINK_DIV_BITS-1:0] r_blink_cnt;

    logic [BLINK_DIV_BITS-1:0] w_blink_next;
    logic                      w_phase;
    logic [3:0]                w_p1_inc;
    logic [3:0]                w_p2_inc;
    logic [3:0]                w_mask_p1;
    logic [3:0]                w_mask_p2;

    // The blink phase is taken from the counter value being loaded this edge,
    // so a registered blank bit always matches the counter MSB that it sits
    // beside.
    assign w_blink_next = r_blink_cnt + 1'b1;
    assign w_phase      = w_blink_next[BLINK_DIV_BITS-1];
    assign w_p1_inc     = p1_score + 4'd1;
    assign w_p2_inc     = p2_score + 4'd1;
    assign w_mask_p1    = {1'b0, w_phase, 2'b00};
    assign w_mask_p2    = {3'b000, w_phase};

    // Free-running blink counter, wraps naturally at 2^BLINK_DIV_BITS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= w_blink_next;
        end
    end

    // Match state machine with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_last_p2   <= 1'b0;
            p1_score    <= 4'd0;
            p2_score    <= 4'd0;
            digit_blank <= 4'b0000;
            game_run    <= 1'b0;
            serve_dir   <= 1'b0;
            winner      <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    game_run    <= 1'b0;
                    digit_blank <= 4'b0000;
                    if (start) begin
                        r_state  <= S_PLAY;
                        game_run <= 1'b1;
                    end
                end

                S_PLAY: begin
                    game_run    <= 1'b1;
                    digit_blank <= 4'b0000;
                    // Player 1 has priority when both pulses coincide.
                    if (p1_point) begin
                        p1_score    <= w_p1_inc;
                        serve_dir   <= 1'b1;
                        game_run    <= 1'b0;
                        r_last_p2   <= 1'b0;
                        digit_blank <= w_mask_p1;
                        if (w_p1_inc == c_WIN) begin
                            r_state <= S_WIN;
                            winner  <= 2'b01;
`ifdef AUTO_RESTART_EN
                            r_hold  <= c_HOLD_LOAD;
`endif
                        end else begin
                            r_state <= S_POINT;
                            r_hold  <= c_HOLD_LOAD;
                        end
                    end else if (p2_point) begin
                        p2_score    <= w_p2_inc;
                        serve_dir   <= 1'b0;
                        game_run    <= 1'b0;
                        r_last_p2   <= 1'b1;
                        digit_blank <= w_mask_p2;
                        if (w_p2_inc == c_WIN) begin
                            r_state <= S_WIN;
                            winner  <= 2'b10;
`ifdef AUTO_RESTART_EN
                            r_hold  <= c_HOLD_LOAD;
`endif
                        end else begin
                            r_state <= S_POINT;
                            r_hold  <= c_HOLD_LOAD;
                        end
                    end
                end

                S_POINT: begin
                    // Counter loaded with HOLD_CYCLES-1 so the pause is
                    // exactly HOLD_CYCLES cycles including the entry edge.
                    game_run    <= 1'b0;
                    digit_blank <= r_last_p2 ? w_mask_p2 : w_mask_p1;
                    if (r_hold == '0) begin
                        r_state     <= S_PLAY;
                        game_run    <= 1'b1;
                        digit_blank <= 4'b0000;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end

                S_WIN: begin
                    game_run    <= 1'b0;
                    digit_blank <= winner[1] ? w_mask_p2 : w_mask_p1;
                    if (start) begin
                        r_state     <= S_PLAY;
                        p1_score    <= 4'd0;
                        p2_score    <= 4'd0;
                        winner      <= 2'b00;
                        serve_dir   <= 1'b0;
                        game_run    <= 1'b1;
                        digit_blank <= 4'b0000;
                    end
`ifdef AUTO_RESTART_EN
                    else if (r_hold == '0) begin
                        r_state     <= S_IDLE;
                        p1_score    <= 4'd0;
                        p2_score    <= 4'd0;
                        winner      <= 2'b00;
                        serve_dir   <= 1'b0;
                        digit_blank <= 4'b0000;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
`endif
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pong_score_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_score_controller
// Description : Directed self-checking bench for pong_score_controller with
//               WIN_SCORE=3, HOLD_CYCLES=8, BLINK_DIV_BITS=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_score_controller;

    logic       clk;
    logic       reset;
    logic       p1_point;
    logic       p2_point;
    logic       start;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [3:0] digit_blank;
    logic       game_run;
    logic       serve_dir;
    logic [1:0] winner;

    int n_cmp = 0;
    int n_err = 0;

    // Reference blink counter: counts edges since reset release, 3 bits wide.
    logic [2:0] r_ref_cnt;

    pong_score_controller #(
        .WIN_SCORE      (3),
        .HOLD_CYCLES    (8),
        .BLINK_DIV_BITS (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .p1_point    (p1_point),
        .p2_point    (p2_point),
        .start       (start),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .digit_blank (digit_blank),
        .game_run    (game_run),
        .serve_dir   (serve_dir),
        .winner      (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) r_ref_cnt <= 3'd0;
        else       r_ref_cnt <= r_ref_cnt + 3'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic pulse_p1();
        p1_point = 1'b1; step(); p1_point = 1'b0;
    endtask

    task automatic pulse_p2();
        p2_point = 1'b1; step(); p2_point = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; p1_point = 1'b0; p2_point = 1'b0; start = 1'b0;
        steps(3);
        check("rst_p1",    32'(p1_score), 32'd0);
        check("rst_p2",    32'(p2_score), 32'd0);
        check("rst_blank", 32'(digit_blank), 32'h0);
        check("rst_run",   32'(game_run), 32'd0);
        check("rst_serve", 32'(serve_dir), 32'd0);
        check("rst_win",   32'(winner), 32'd0);
        reset = 1'b0;

        // Start, then player 1 scores; pause must last exactly 8 cycles.
        pulse_start();
        check("start_run", 32'(game_run), 32'd1);
        pulse_p1();
        check("p1_score1", 32'(p1_score), 32'd1);
        check("p1_serve",  32'(serve_dir), 32'd1);
        check("p1_run0",   32'(game_run), 32'd0);
        check("p1_blank0", 32'(digit_blank), 32'({1'b0, r_ref_cnt[2], 2'b00}));
        // Pulses and start during the pause are ignored.
        for (int i = 1; i < 8; i++) begin
            p1_point = (i == 2);
            p2_point = (i == 3);
            start    = (i == 4);
            step();
            check("hold_run",   32'(game_run), 32'd0);
            check("hold_blank", 32'(digit_blank), 32'({1'b0, r_ref_cnt[2], 2'b00}));
        end
        p1_point = 1'b0; p2_point = 1'b0; start = 1'b0;
        step();
        check("hold_end_run",   32'(game_run), 32'd1);
        check("hold_end_blank", 32'(digit_blank), 32'h0);
        check("hold_p1",        32'(p1_score), 32'd1);
        check("hold_p2",        32'(p2_score), 32'd0);

        // Simultaneous points: player 1 wins priority.
        p1_point = 1'b1; p2_point = 1'b1; step(); p1_point = 1'b0; p2_point = 1'b0;
        check("both_p1",    32'(p1_score), 32'd2);
        check("both_p2",    32'(p2_score), 32'd0);
        check("both_serve", 32'(serve_dir), 32'd1);
        check("both_run",   32'(game_run), 32'd0);

        // Asynchronous reset in POINT with p1_score=2, checked before any edge.
        #2 reset = 1'b1;
        #1;
        check("arst_p1",    32'(p1_score), 32'd0);
        check("arst_p2",    32'(p2_score), 32'd0);
        check("arst_run",   32'(game_run), 32'd0);
        check("arst_win",   32'(winner), 32'd0);
        check("arst_blank", 32'(digit_blank), 32'h0);
        check("arst_serve", 32'(serve_dir), 32'd0);
        step();
        reset = 1'b0;

        // IDLE ignores points.
        pulse_p1();
        pulse_p2();
        check("idle_p1",  32'(p1_score), 32'd0);
        check("idle_p2",  32'(p2_score), 32'd0);
        check("idle_run", 32'(game_run), 32'd0);

        // Player 2 plays to 3.
        pulse_start();
        check("start2_run", 32'(game_run), 32'd1);
        for (int k = 1; k <= 2; k++) begin
            pulse_p2();
            check("p2_score",  32'(p2_score), 32'(k));
            check("p2_serve",  32'(serve_dir), 32'd0);
            check("p2_blank",  32'(digit_blank), 32'({3'b000, r_ref_cnt[2]}));
            steps(8);
            check("p2_resume", 32'(game_run), 32'd1);
        end
        pulse_p2();
        check("p2_win",      32'(winner), 32'd2);
        check("p2_win_scr",  32'(p2_score), 32'd3);
        check("p2_win_run",  32'(game_run), 32'd0);
        for (int i = 0; i < 5; i++) begin
            p2_point = (i == 1);
            step();
            check("win_blank", 32'(digit_blank), 32'({3'b000, r_ref_cnt[2]}));
        end
        p2_point = 1'b0;
        check("win_frozen", 32'(p2_score), 32'd3);
        check("win_hold",   32'(winner), 32'd2);
        pulse_start();
        check("restart_p1",    32'(p1_score), 32'd0);
        check("restart_p2",    32'(p2_score), 32'd0);
        check("restart_win",   32'(winner), 32'd0);
        check("restart_run",   32'(game_run), 32'd1);
        check("restart_serve", 32'(serve_dir), 32'd0);
        check("restart_blank", 32'(digit_blank), 32'h0);

        // Player 1 plays to 3.
        for (int k = 1; k <= 2; k++) begin
            pulse_p1();
            steps(8);
        end
        pulse_p1();
        check("p1_win",     32'(winner), 32'd1);
        check("p1_win_scr", 32'(p1_score), 32'd3);
        check("p1_win_blk", 32'(digit_blank), 32'({1'b0, r_ref_cnt[2], 2'b00}));
`ifdef AUTO_RESTART_EN
        steps(7);
        check("auto_still_win", 32'(winner), 32'd1);
        step();
        check("auto_win",   32'(winner), 32'd0);
        check("auto_p1",    32'(p1_score), 32'd0);
        check("auto_p2",    32'(p2_score), 32'd0);
        check("auto_run",   32'(game_run), 32'd0);
        check("auto_serve", 32'(serve_dir), 32'd0);
        pulse_start();
        check("auto_idle_start", 32'(game_run), 32'd1);
`else
        steps(100);
        check("held_win", 32'(winner), 32'd1);
        check("held_p1",  32'(p1_score), 32'd3);
        check("held_run", 32'(game_run), 32'd0);
        pulse_start();
        check("held_restart_run", 32'(game_run), 32'd1);
        check("held_restart_p1",  32'(p1_score), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
